load_store_unit: RTL

- MEM-stage initiator for data accesses in the pipelined RV32I core.
- Takes load/store ops from the EX/MEM register and drives a word-addressed valid/ready request/response data bus (data memory responder on far end).
- Generates byte enables and store-lane replication; extracts and sign/zero-extends load data.
- Stalls the pipeline until each access completes.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared states, funct3 codes and byte-enable/alignment helpers for the LSU
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] carries the access size for both signed and unsigned codes
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane replication and load lane extraction/extension
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] store_lanes_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i[1:0])
      2'b00:   store_lanes_o = {4{store_data_i[7:0]}};
      2'b01:   store_lanes_o = {2{store_data_i[15:0]}};
      default: store_lanes_o = store_data_i;
    endcase

    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage data bus initiator; LSU_MISALIGN_TRAP_EN turns misaligned ops into bus-free faults
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int RSP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_we,
  input  logic [2:0]        op_funct3,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              bus_err,
  output logic              misaligned,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [3:0]        req_be,
  output logic [31:0]       req_wdata,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_rdata
);

  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);

  lsu_state_e        state_q;
  logic [2:0]        f3_q;
  logic [1:0]        addr_lo_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_valid_q, req_we_q, done_q, bus_err_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [3:0]        req_be_q;
  logic [31:0]       req_wdata_q, load_data_q;
  logic [2:0]        align_f3;
  logic [1:0]        align_a;
  logic [31:0]       store_lanes, load_ext;

  // One aligner serves both directions: op fields while IDLE, latched fields afterwards
  assign align_f3 = (state_q == IDLE) ? op_funct3 : f3_q;
  assign align_a  = (state_q == IDLE) ? op_addr[1:0] : addr_lo_q;
  assign cnt_d    = cnt_q + CNT_W'(1);

  lsu_lane_align u_align (
    .funct3_i     (align_f3),
    .addr_lo_i    (align_a),
    .store_data_i (op_wdata),
    .rdata_i      (rsp_rdata),
    .store_lanes_o(store_lanes),
    .load_data_o  (load_ext)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_q;
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      f3_q        <= 3'b000;
      addr_lo_q   <= 2'b00;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_be_q    <= 4'b0000;
      req_wdata_q <= 32'h0;
      done_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      load_data_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            f3_q        <= op_funct3;
            addr_lo_q   <= op_addr[1:0];
            cnt_q       <= '0;
            req_we_q    <= op_we;
            req_addr_q  <= {op_addr[ADDR_W-1:2], 2'b00};
            req_be_q    <= be_gen(op_funct3, op_addr[1:0]);
            req_wdata_q <= store_lanes;
            bus_err_q   <= 1'b0;
            load_data_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_q <= is_misaligned(op_funct3, op_addr[1:0]);
            if (is_misaligned(op_funct3, op_addr[1:0])) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              req_valid_q <= 1'b1;
              state_q     <= REQ;
            end
`else
            req_valid_q <= 1'b1;
            state_q     <= REQ;
`endif
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            if (req_we_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= RSP;
            end
          end
        end
        RSP: begin
          cnt_q <= cnt_d;
          // A response arriving on the limit cycle still wins over the timeout
          if (rsp_valid) begin
            load_data_q <= load_ext;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_d == CNT_W'(RSP_TIMEOUT)) begin
            bus_err_q   <= 1'b1;
            load_data_q <= 32'h0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  assign stall     = op_valid && (state_q != DONE);
  assign done      = done_q;
  assign load_data = load_data_q;
  assign bus_err   = bus_err_q;
  assign req_valid = req_valid_q;
  assign req_we    = req_we_q;
  assign req_addr  = req_addr_q;
  assign req_be    = req_be_q;
  assign req_wdata = req_wdata_q;

endmodule
